// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access sizes, FSM states
// and the alignment rule used to reject requests up front.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Size 11 is illegal and always treated as an error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: merges store data into a read word and
// extracts/extends the addressed lane of a read word for loads.
import mem_pkg::*;

module mem_lane_align (
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]  = wdata_i[7:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns byte/half/word load/store requests into aligned
// memory reads and writes, using read-modify-write for sub-word stores.
import mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_e            state_q, state_d;
  logic              we_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q, addr_out_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, wdata_out_q;
  logic [DATA_W-1:0] merged, load_data;
  logic [ADDR_W-1:0] aligned_addr;
  logic              req_err;

  assign aligned_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_err      = misaligned(req_size, req_addr[1:0]);

  mem_lane_align u_align (
    .rdata_i   (rdata_q),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .addr_lo_i (addr_q[1:0]),
    .merged_o  (merged),
    .load_o    (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_out_q  <= '0;
      wdata_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        err_q    <= req_err;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == RD) rdata_q <= ReadData;
      if (state_q == RD || state_q == WR) addr_out_q <= aligned_addr;
      if (state_q == WR) wdata_out_q <= merged;
    end
  end

  // Memory-side buses only follow the live request during RD/WR and
  // otherwise hold whatever the last access drove.
  always_comb begin
    state_d  = state_q;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                             state_d = RESP;
          else if (req_we && req_size == SZ_WORD)  state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD: begin
        MemRead = 1'b1;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        MemWrite = 1'b1;
        state_d  = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Address    = (state_q == RD || state_q == WR) ? aligned_addr : addr_out_q;
  assign WriteData  = (state_q == WR) ? merged : wdata_out_q;
  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = (state_q == RESP && !we_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256x32 memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        preload;
  logic [31:0] mem [256];
  int          testsRun;
  int          testsFailed;
  int          accessCount;
  int          bothHigh;
  int          accBefore;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ReadData = mem[Address[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      mem[4] <= 32'h8899AABB;
      mem[8] <= 32'h00000000;
    end else if (MemWrite) begin
      mem[Address[9:2]] <= WriteData;
    end
  end

  always @(posedge clk) begin
    if (MemRead && MemWrite) bothHigh <= bothHigh + 1;
    if (MemRead || MemWrite) accessCount <= accessCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Presents one request at a negedge; returns just after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    checkBit("ready_before_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic doLoad(input string tag, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] expData);
    applyStimulus(1'b0, size, sgn, addr, 32'h0);
    @(negedge clk);
    checkBit({tag, "_rd"}, MemRead, 1'b1);
    checkOutput({tag, "_addr"}, Address, {addr[31:2], 2'b00});
    @(negedge clk);
    checkBit({tag, "_valid"}, resp_valid, 1'b1);
    checkOutput({tag, "_data"}, resp_rdata, expData);
    checkBit({tag, "_err"}, resp_err, 1'b0);
    @(negedge clk);
    checkBit({tag, "_pulse"}, resp_valid, 1'b0);
  endtask

  task automatic doError(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr);
    applyStimulus(we, size, 1'b0, addr, 32'h12345678);
    @(negedge clk);
    checkBit({tag, "_valid"}, resp_valid, 1'b1);
    checkBit({tag, "_err"}, resp_err, 1'b1);
    checkOutput({tag, "_data"}, resp_rdata, 32'h0);
    checkBit({tag, "_rd"}, MemRead, 1'b0);
    checkBit({tag, "_wr"}, MemWrite, 1'b0);
    @(negedge clk);
    checkBit({tag, "_idle"}, stall, 1'b0);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    accessCount = 0;
    bothHigh = 0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    reset = 1'b1;
    preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    preload = 1'b0;
    @(negedge clk);

    checkBit("rst_ready", req_ready, 1'b1);
    checkBit("rst_stall", stall, 1'b0);
    checkBit("rst_memread", MemRead, 1'b0);
    checkBit("rst_memwrite", MemWrite, 1'b0);
    checkOutput("rst_address", Address, 32'h0);
    checkOutput("rst_wdata", WriteData, 32'h0);
    checkBit("rst_resp_valid", resp_valid, 1'b0);
    checkBit("rst_resp_err", resp_err, 1'b0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);

    doLoad("lw_10",  2'b10, 1'b0, 32'h10, 32'h8899AABB);
    doLoad("lb_13",  2'b00, 1'b1, 32'h13, 32'hFFFFFF88);
    doLoad("lbu_11", 2'b00, 1'b0, 32'h11, 32'h000000AA);
    doLoad("lh_12",  2'b01, 1'b1, 32'h12, 32'hFFFF8899);
    doLoad("lhu_10", 2'b01, 1'b0, 32'h10, 32'h0000AABB);

    // Byte store via read-modify-write
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677);
    @(negedge clk);
    checkBit("sb_rd", MemRead, 1'b1);
    checkBit("sb_rd_nowr", MemWrite, 1'b0);
    checkOutput("sb_rd_addr", Address, 32'h10);
    checkBit("sb_stall1", stall, 1'b1);
    @(negedge clk);
    checkBit("sb_wr", MemWrite, 1'b1);
    checkBit("sb_wr_nord", MemRead, 1'b0);
    checkOutput("sb_wdata", WriteData, 32'h889977BB);
    checkBit("sb_stall2", stall, 1'b1);
    @(negedge clk);
    checkBit("sb_resp", resp_valid, 1'b1);
    checkOutput("sb_resp_data", resp_rdata, 32'h0);
    checkBit("sb_stall3", stall, 1'b1);
    @(negedge clk);
    checkBit("sb_stall_done", stall, 1'b0);
    checkOutput("sb_mem", mem[4], 32'h889977BB);
    doLoad("lw_after_sb", 2'b10, 1'b0, 32'h10, 32'h889977BB);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
    @(negedge clk);
    @(negedge clk);
    checkOutput("restore_wdata", WriteData, 32'h8899AABB);
    @(negedge clk);
    @(negedge clk);
    checkOutput("restore_mem", mem[4], 32'h8899AABB);

    accBefore = accessCount;
    doError("sh_11", 1'b1, 2'b01, 32'h11);
    doError("lw_12", 1'b0, 2'b10, 32'h12);
    doError("sz_11", 1'b0, 2'b11, 32'h10);
    checkOutput("err_no_access", accessCount, accBefore);
    checkOutput("err_mem", mem[4], 32'h8899AABB);

    // Reset landing in the middle of a word store's WR cycle
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checkBit("sw_wr", MemWrite, 1'b1);
    checkOutput("sw_wdata", WriteData, 32'hDEADBEEF);
    #1 reset = 1'b1;
    #1;
    checkBit("rst_mid_memwrite", MemWrite, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid_mem", mem[4], 32'h8899AABB);
    @(negedge clk);
    checkBit("rst_mid_ready", req_ready, 1'b1);
    checkBit("rst_mid_noresp1", resp_valid, 1'b0);
    @(negedge clk);
    checkBit("rst_mid_noresp2", resp_valid, 1'b0);

    // Back-to-back: the load is held on req_valid while the store is busy
    @(negedge clk);
    req_we = 1'b1;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_we = 1'b0;
    req_wdata = 32'h0;
    @(negedge clk);
    checkBit("b2b_busy1", req_ready, 1'b0);
    checkBit("b2b_wr", MemWrite, 1'b1);
    checkOutput("b2b_wdata", WriteData, 32'hCAFEF00D);
    @(negedge clk);
    checkBit("b2b_sw_resp", resp_valid, 1'b1);
    checkBit("b2b_busy2", req_ready, 1'b0);
    @(negedge clk);
    checkBit("b2b_ready", req_ready, 1'b1);
    checkBit("b2b_no_early_rd", MemRead, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkBit("b2b_lw_rd", MemRead, 1'b1);
    checkOutput("b2b_lw_addr", Address, 32'h20);
    @(negedge clk);
    checkBit("b2b_lw_resp", resp_valid, 1'b1);
    checkOutput("b2b_lw_data", resp_rdata, 32'hCAFEF00D);

    checkOutput("never_both", bothHigh, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
